// File: rtl/tile_blit_engine.sv
// Tile blit engine: raster-scans one grid tile and streams pixels to the VGA adapter.
// Define TILE_BLIT_TRANSPARENT_EN to skip copy-mode pixels equal to KEY_COLOUR.
module tile_blit_engine #(
  parameter int TILE_W   = 20,
  parameter int TILE_H   = 20,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int GRID_W   = 4,
  parameter int COLOUR_W = 9,
  parameter int ADDR_W   = 15,
  parameter int RD_LAT   = 1
`ifdef TILE_BLIT_TRANSPARENT_EN
  ,
  parameter logic [COLOUR_W-1:0] KEY_COLOUR = COLOUR_W'(9'h1F8)
`endif
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [GRID_W-1:0]   grid_x,
  input  logic [GRID_W-1:0]   grid_y,
  input  logic                mode,
  input  logic [COLOUR_W-1:0] fill_colour,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [COLOUR_W-1:0] mem_q,
  output logic                plot,
  output logic [7:0]          x,
  output logic [6:0]          y,
  output logic [COLOUR_W-1:0] colour
);

  localparam int CW = 16;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]       cx_q, cx_d;
  logic [CW-1:0]       cy_q, cy_d;
  logic [GRID_W-1:0]   gx_q, gy_q;
  logic                mode_q;
  logic [COLOUR_W-1:0] fill_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  // Slot 0 is the pixel being issued; slot RD_LAT meets mem_q.
  logic [RD_LAT:0]      vld_q;
  logic [RD_LAT:0]      inr_q;
  logic [RD_LAT:0][7:0] xs_q;
  logic [RD_LAT:0][6:0] ys_q;

  logic              accept, load, last, in_rng, keyed;
  logic [GRID_W-1:0] gx_s, gy_s;
  logic [CW-1:0]     px, py;

  assign last = (cx_q == CW'(TILE_W - 1))
             && (cy_q == CW'(TILE_H - 1));

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    accept  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          load    = 1'b1;
          cx_d    = '0;
          cy_d    = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (last) begin
          state_d = DRAIN;
        end else begin
          load = 1'b1;
          if (cx_q == CW'(TILE_W - 1)) begin
            cx_d = '0;
            cy_d = cy_q + 1'b1;
          end else begin
            cx_d = cx_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!(|vld_q[RD_LAT-1:0])) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  assign gx_s   = accept ? grid_x : gx_q;
  assign gy_s   = accept ? grid_y : gy_q;
  assign px     = CW'(gx_s) * CW'(TILE_W) + cx_d;
  assign py     = CW'(gy_s) * CW'(TILE_H) + cy_d;
  assign in_rng = (px < CW'(SCREEN_W)) && (py < CW'(SCREEN_H));

  always_comb begin
    addr_d = addr_q;
    if (load) begin
      addr_d = in_rng
        ? ADDR_W'(32'(py) * 32'(SCREEN_W) + 32'(px))
        : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cx_q   <= '0;
      cy_q   <= '0;
      gx_q   <= '0;
      gy_q   <= '0;
      mode_q <= 1'b0;
      fill_q <= '0;
      addr_q <= '0;
      vld_q  <= '0;
      inr_q  <= '0;
      xs_q   <= '0;
      ys_q   <= '0;
    end else begin
      cx_q   <= cx_d;
      cy_q   <= cy_d;
      addr_q <= addr_d;
      if (accept) begin
        gx_q   <= grid_x;
        gy_q   <= grid_y;
        mode_q <= mode;
        fill_q <= fill_colour;
      end
      vld_q[0] <= load;
      if (load) begin
        xs_q[0]  <= 8'(px);
        ys_q[0]  <= 7'(py);
        inr_q[0] <= in_rng;
      end
      for (int i = 1; i <= RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        inr_q[i] <= inr_q[i-1];
        xs_q[i]  <= xs_q[i-1];
        ys_q[i]  <= ys_q[i-1];
      end
    end
  end

`ifdef TILE_BLIT_TRANSPARENT_EN
  assign keyed = !mode_q && (mem_q == KEY_COLOUR);
`else
  assign keyed = 1'b0;
`endif

  assign busy     = (state_q == SCAN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);
  assign mem_addr = addr_q;
  assign x        = xs_q[RD_LAT];
  assign y        = ys_q[RD_LAT];
  assign plot     = vld_q[RD_LAT] & inr_q[RD_LAT] & ~keyed;
  assign colour   = vld_q[RD_LAT]
                  ? (mode_q ? fill_q : mem_q)
                  : '0;

endmodule

// File: tb/tb_tile_blit_engine.sv
// Bench for tile_blit_engine: three configs (default, TILE_W=24, RD_LAT=3)
// checked against a tile-level pixel list model and fixed vectors.
module tb_tile_blit_engine;

  localparam int NI = 3;
  localparam int SW = 160;
  localparam int SH = 120;
  localparam int TH = 20;
  localparam logic [8:0] KEY = 9'h1F8;
`ifdef TILE_BLIT_TRANSPARENT_EN
  localparam int KEY_ON = 1;
`else
  localparam int KEY_ON = 0;
`endif
  localparam int NK = 10 * KEY_ON;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [8:0] c;
  } pix_t;

  typedef struct {
    int g;
    int gx;
    int gy;
    int md;
    logic [8:0] fl;
    int hold;
    int n;
    int lat;
  } vec_t;

  logic clk = 1'b0;
  logic [NI-1:0] resetn_v, start_v, mode_v;
  logic [NI-1:0] busy_v, done_v, plot_v;
  logic [NI-1:0][3:0] gx_v, gy_v;
  logic [NI-1:0][8:0] fill_v, q_v, col_v;
  logic [NI-1:0][14:0] addr_v;
  logic [NI-1:0][7:0] x_v;
  logic [NI-1:0][6:0] y_v;
  logic [8:0] ram [SW*SH];

  int checks = 0;
  int failures = 0;
  pix_t expq[$];
  pix_t gotq[$];
  vec_t tbl[9];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int LAT = (g == 2) ? 3 : 1;
    logic [8:0] dl_q [LAT];
    always @(posedge clk) begin
      dl_q[0] <= (int'(addr_v[g]) < SW * SH) ? ram[addr_v[g]] : 9'h000;
      for (int i = 1; i < LAT; i++) dl_q[i] <= dl_q[i-1];
    end
    assign q_v[g] = dl_q[LAT-1];

    tile_blit_engine #(
      .TILE_W((g == 1) ? 24 : 20),
      .RD_LAT(LAT)
    ) dut (
      .clk(clk),
      .resetn(resetn_v[g]),
      .start(start_v[g]),
      .grid_x(gx_v[g]),
      .grid_y(gy_v[g]),
      .mode(mode_v[g]),
      .fill_colour(fill_v[g]),
      .busy(busy_v[g]),
      .done(done_v[g]),
      .mem_addr(addr_v[g]),
      .mem_q(q_v[g]),
      .plot(plot_v[g]),
      .x(x_v[g]),
      .y(y_v[g]),
      .colour(col_v[g])
    );
  end

  function automatic int tw(input int g);
    return (g == 1) ? 24 : 20;
  endfunction

  function automatic int lat(input int g);
    return (g == 2) ? 3 : 1;
  endfunction

  task automatic chk(input bit ok, input string nm,
                     input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  task automatic scramble(input int g);
    gx_v[g]   = 4'($urandom);
    gy_v[g]   = 4'($urandom);
    mode_v[g] = 1'($urandom);
    fill_v[g] = 9'($urandom);
  endtask

  // Expected plotted pixels of one tile, in raster order.
  task automatic build_model(input int g, input int gx, input int gy,
                             input int md, input logic [8:0] fl);
    expq.delete();
    for (int cy = 0; cy < TH; cy++) begin
      for (int cx = 0; cx < tw(g); cx++) begin
        int px;
        int py;
        logic [8:0] c;
        pix_t p;
        px = gx * tw(g) + cx;
        py = gy * TH + cy;
        if (px < SW && py < SH) begin
          c = (md != 0) ? fl : ram[py * SW + px];
          if (!(KEY_ON != 0 && md == 0 && c == KEY)) begin
            p.x = 8'(px);
            p.y = 7'(py);
            p.c = c;
            expq.push_back(p);
          end
        end
      end
    end
  endtask

  task automatic run_blit(input int g, input int gx, input int gy,
                          input int md, input logic [8:0] fl,
                          input int hold, input int exp_n,
                          input int exp_lat);
    int tot;
    int dk;
    int lpx;
    int lpy;
    int la;
    int done_k;
    int ndone;
    int busy_bad;
    int mism;
    int first;
    pix_t p;
    tot = tw(g) * TH;
    dk = tot + lat(g) + 1;
    lpx = gx * tw(g) + tw(g) - 1;
    lpy = gy * TH + TH - 1;
    la = (lpx < SW && lpy < SH) ? lpy * SW + lpx : 0;
    done_k = -1;
    ndone = 0;
    busy_bad = 0;
    build_model(g, gx, gy, md, fl);
    gotq.delete();
    @(negedge clk);
    gx_v[g] = 4'(gx);
    gy_v[g] = 4'(gy);
    mode_v[g] = 1'(md);
    fill_v[g] = fl;
    start_v[g] = 1'b1;
    for (int k = 1; k <= dk + 3; k++) begin
      @(negedge clk);
      if (plot_v[g]) begin
        p.x = x_v[g];
        p.y = y_v[g];
        p.c = col_v[g];
        gotq.push_back(p);
      end
      if (done_v[g]) begin
        ndone++;
        if (done_k < 0) done_k = k;
      end
      if (busy_v[g] !== (k <= tot + lat(g))) busy_bad++;
      if (k == tot)
        chk(int'(addr_v[g]) == la, "last_addr", int'(addr_v[g]), la);
      if (g == 0 && gx == 0 && gy == 0 && md == 0) begin
        if (k == 46)
          chk(addr_v[g] == 15'd325, "addr_5_2", int'(addr_v[g]), 325);
        if (k == 47)
          chk(col_v[g] == ram[325], "col_5_2",
              int'(col_v[g]), int'(ram[325]));
      end
      start_v[g] = (hold != 0) && (k != 100) && (k <= dk);
      scramble(g);
    end
    start_v[g] = 1'b0;
    chk(ndone == 1, "done_cnt", ndone, 1);
    chk(done_k == dk, "done_cyc", done_k, dk);
    if (exp_lat >= 0) chk(done_k == exp_lat, "done_tbl", done_k, exp_lat);
    chk(busy_bad == 0, "busy", busy_bad, 0);
    chk(gotq.size() == expq.size(), "plots", gotq.size(), expq.size());
    if (exp_n >= 0) chk(gotq.size() == exp_n, "plots_tbl", gotq.size(), exp_n);
    mism = 0;
    first = -1;
    for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
      if (gotq[i] != expq[i]) begin
        mism++;
        if (first < 0) first = i;
      end
    end
    if (first >= 0)
      $display("  pixel %0d got %h want %h", first, gotq[first], expq[first]);
    chk(mism == 0, "pix_seq", mism, 0);
  endtask

  task automatic reset_abort();
    int nd;
    int busy_bad;
    nd = 0;
    busy_bad = 0;
    @(negedge clk);
    gx_v[0] = 4'd0;
    gy_v[0] = 4'd0;
    mode_v[0] = 1'b0;
    start_v[0] = 1'b1;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      if (k == 150) resetn_v[0] = 1'b0;
    end
    @(negedge clk);
    chk(plot_v[0] == 1'b0, "rst_plot", int'(plot_v[0]), 0);
    chk(busy_v[0] == 1'b0, "rst_busy", int'(busy_v[0]), 0);
    resetn_v[0] = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done_v[0]) nd++;
      if (busy_v[0]) busy_bad++;
    end
    chk(nd == 0, "rst_nodone", nd, 0);
    chk(busy_bad == 0, "rst_idle", busy_bad, 0);
  endtask

  initial begin
    logic [8:0] v;
    resetn_v = '0;
    start_v = '0;
    mode_v = '0;
    gx_v = '0;
    gy_v = '0;
    fill_v = '0;
    for (int i = 0; i < SW * SH; i++) begin
      v = 9'($urandom);
      if (v == KEY) v = 9'h000;
      ram[i] = v;
    end
    for (int k = 0; k < 10; k++) ram[k * SW + 2 * k] = KEY;

    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk(addr_v[g] == '0, "rst_addr", int'(addr_v[g]), 0);
      chk({busy_v[g], done_v[g], plot_v[g]} == 3'b000, "rst_flags",
          int'({busy_v[g], done_v[g], plot_v[g]}), 0);
      chk({x_v[g], y_v[g], col_v[g]} == 24'h0, "rst_pix",
          int'({x_v[g], y_v[g], col_v[g]}), 0);
    end
    resetn_v = '1;
    @(negedge clk);

    tbl[0] = '{0, 0, 0, 0, 9'h000, 0, 400 - NK, 402};
    tbl[1] = '{0, 7, 5, 1, 9'h1FF, 0, 400, 402};
    tbl[2] = '{1, 6, 0, 0, 9'h000, 0, 320, 482};
    tbl[3] = '{2, 0, 0, 0, 9'h000, 0, 400 - NK, 404};
    tbl[4] = '{0, 7, 0, 0, 9'h000, 0, 400, 402};
    tbl[5] = '{0, 8, 0, 1, 9'h055, 0, 0, 402};
    tbl[6] = '{2, 0, 6, 0, 9'h000, 0, 0, 404};
    tbl[7] = '{1, 0, 0, 0, 9'h000, 1, 480 - NK, 482};
    tbl[8] = '{1, 15, 15, 1, 9'h0AA, 0, 0, 482};
    for (int i = 0; i < 9; i++)
      run_blit(tbl[i].g, tbl[i].gx, tbl[i].gy, tbl[i].md, tbl[i].fl,
               tbl[i].hold, tbl[i].n, tbl[i].lat);

    reset_abort();
    run_blit(0, 0, 0, 0, 9'h000, 0, 400 - NK, 402);

    for (int r = 0; r < 6; r++)
      run_blit($urandom_range(0, NI - 1), $urandom_range(0, 9),
               $urandom_range(0, 7), $urandom_range(0, 1),
               9'($urandom), 0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
